c2_serial_subtractor: RTL and testbench
=======================================

Name: c2_serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes i1 - i2 LSB-first, one bit per clock.
- Companion to the ripple C2 adder. It is the subtract direction, trading area for latency.
- Intended for datapaths that have multi-cycle slack and sit behind a start/done handshake.
- Result format matches the adder's: size-bit difference plus one extra MSB carrying the borrow-out.

Parameters:
- size, 5, operand width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on rising clk edge when block is IDLE or DONE.
- i1  input  size  minuend; sampled only on the edge that accepts start.
- i2  input  size  subtrahend; sampled only on the edge that accepts start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse; result valid.
- o  output  size+1  {borrow_out, difference}; held stable until next accepted start.

Behaviour:
- Reset: sync, active-high, one clk edge. State=IDLE; o=0, busy=0, done=0, internal shift regs, bit counter and borrow all cleared. rst has priority over start.
- States:
  - IDLE: busy=0, done=0. start=1 -> load i1/i2 into shift regs A/B, borrow=0, count=0 -> RUN.
  - RUN: busy=1. Each edge:
    - d = A[0]^B[0]^borrow;
    - borrow <= (~A[0]&B[0]) | (~(A[0]^B[0])&borrow);
    - A, B shift right by 1; d shifts into the MSB of diff reg; count++.
    - On the edge where count reaches size-1 -> load o <= {borrow_next, diff_next} and go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle.
    - start=1 -> accept as in IDLE (back-to-back, no bubble) -> RUN.
    - else -> IDLE.
- Latency: start accepted at edge k; busy=1 during cycles after edges k..k+size-1. o updates and done=1 in the cycle after edge k+size. Throughput is one result per size+1 cycles.
- o is updated only on completion, never during RUN. The previous result stays visible while a new operation runs.
- Arithmetic:
  - o[size-1:0] = (i1 - i2) mod 2^size.
  - o[size] = 1 iff unsigned i1 < unsigned i2.
  - For signed use, o[size-1:0] is the two's-complement difference. Overflow is not flagged.
- start during RUN: ignored; i1/i2 changes during RUN have no effect.
- rst during RUN: aborts; no done pulse; o cleared to 0.
- rst and start in the same cycle: reset wins; block is IDLE afterwards.
- Equal operands: o = 0, borrow 0. Zero operands are handled identically (full size cycles, no early exit).

Test Plan (size=5):
- Reset, then start with i1=13, i2=6 -> busy for 5 cycles, done pulse in the 6th cycle after the start edge, o=6'b000111.
- i1=6, i2=13 -> o=6'b111001 (diff 25, borrow 1). i1=0, i2=1 -> o=6'b111111. i1=31, i2=31 -> o=6'b000000. i1=31, i2=0 -> o=6'b011111.
- Start 13-6; pulse start with i1=1, i2=2 on cycle 3 of RUN -> ignored; done once with o=6'b000111.
- Start held high continuously with 20-3 then 3-20 presented at the accept edges -> done pulses 6 cycles apart, no idle gap; o=6'b010001, then 6'b101111.
- Assert rst on cycle 2 of RUN -> next cycle busy=0, done=0, o=0. Stays IDLE until the next start, which then completes normally.
- Random sweep: 500 operand pairs vs the reference model {i1<i2, (i1-i2) mod 32}. Check busy/done timing every op and that o is stable between done pulses.

Source files
------------

// File: rtl/c2_serial_subtractor.sv
// c2_serial_subtractor: bit-serial two's-complement subtractor, LSB-first, {borrow_out, i1-i2}
module c2_serial_subtractor #(
  parameter int size = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] i1,
  input  logic [size-1:0] i2,
  output logic            busy,
  output logic            done,
  output logic [size:0]   o
);
  localparam int cw = $clog2(size);
  typedef enum logic [1:0] {idle, run, fin} state_t;
  state_t state, state_n;
  logic [size-1:0] a, b, diff;
  logic [cw-1:0] cnt;
  logic borrow, borrow_n, d, last, accept;
  always_comb begin
    d = a[0] ^ b[0] ^ borrow;
    borrow_n = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & borrow);
    last = cnt == cw'(size - 1);
    accept = state != run && start;
  end
  always_ff @(posedge clk)
    state <= rst ? idle : state_n;
  always_comb
    state_n = state == run ? (last ? fin : run) : (start ? run : idle);
  always_comb begin
    busy = state == run;
    done = state == fin;
  end
  // o only changes on completion, so the previous result stays visible during RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      diff <= '0;
      cnt <= '0;
      borrow <= 1'b0;
      o <= '0;
    end else if (accept) begin
      a <= i1;
      b <= i2;
      cnt <= '0;
      borrow <= 1'b0;
    end else if (state == run) begin
      a <= a >> 1;
      b <= b >> 1;
      diff <= {d, diff[size-1:1]};
      borrow <= borrow_n;
      cnt <= cnt + 1'b1;
      if (last) o <= {borrow_n, d, diff[size-1:1]};
    end
  end
endmodule

// File: tb/tb_c2_serial_subtractor.sv
// tb_c2_serial_subtractor: directed table, handshake corner cases and a random sweep
module tb_c2_serial_subtractor;
  logic clk = 0, rst = 1, start = 0;
  logic [4:0] i1 = 0, i2 = 0;
  logic busy, done;
  logic [5:0] o;
  int checks = 0, errors = 0;
  typedef struct {logic [4:0] x; logic [4:0] y; logic [5:0] e;} vec_t;
  vec_t v[7];
  c2_serial_subtractor #(.size(5)) dut (.clk(clk), .rst(rst), .start(start), .i1(i1), .i2(i2),
    .busy(busy), .done(done), .o(o));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic do_op(input logic [4:0] x, input logic [4:0] y, input logic [5:0] e);
    logic [5:0] prev;
    prev = o;
    @(negedge clk);
    start = 1; i1 = x; i2 = y;
    @(posedge clk); #1;
    start = 0; i1 = ~x; i2 = ~y;
    for (int j = 0; j < 5; j++) begin
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      chk("o_stable", o, prev);
      @(posedge clk); #1;
    end
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
    chk("result", o, e);
    @(posedge clk); #1;
    chk("done_clear", done, 0);
    chk("o_hold", o, e);
  endtask
  initial begin
    logic [5:0] o1, o2;
    int n, c1, c2;
    logic [4:0] x, y, dd;
    v[0] = '{5'd13, 5'd6, 6'b000111};
    v[1] = '{5'd6, 5'd13, 6'b111001};
    v[2] = '{5'd0, 5'd1, 6'b111111};
    v[3] = '{5'd31, 5'd31, 6'b000000};
    v[4] = '{5'd31, 5'd0, 6'b011111};
    v[5] = '{5'd20, 5'd3, 6'b010001};
    v[6] = '{5'd3, 5'd20, 6'b101111};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o", o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 0;
    for (int k = 0; k < 7; k++) do_op(v[k].x, v[k].y, v[k].e);
    // start pulsed mid-run is ignored
    @(negedge clk);
    start = 1; i1 = 13; i2 = 6;
    @(posedge clk); #1;
    start = 0;
    n = 0; o1 = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 3) begin
        @(negedge clk);
        start = 1; i1 = 1; i2 = 2;
      end
      @(posedge clk); #1;
      start = 0;
      if (done) begin n++; o1 = o; end
    end
    chk("ignore_cnt", n, 1);
    chk("ignore_o", o1, 6'b000111);
    // start held high: back-to-back operations without a bubble
    @(negedge clk);
    start = 1; i1 = 20; i2 = 3;
    @(posedge clk); #1;
    i1 = 3; i2 = 20;
    c1 = 0; c2 = 0; o1 = 0; o2 = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 6) begin
        start = 0;
        chk("b2b_busy", busy, 1);
      end
      if (done && c1 == 0) begin c1 = c; o1 = o; end
      else if (done) begin c2 = c; o2 = o; end
    end
    chk("b2b_c1", c1, 5);
    chk("b2b_c2", c2, 11);
    chk("b2b_o1", o1, 6'b010001);
    chk("b2b_o2", o2, 6'b101111);
    // reset aborts a running operation
    @(negedge clk);
    start = 1; i1 = 13; i2 = 6;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_o", o, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_o", o, 0);
    do_op(13, 6, 6'b000111);
    // reset and start together: reset wins
    @(negedge clk);
    rst = 1; start = 1;
    @(posedge clk); #1;
    rst = 0; start = 0;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_o", o, 0);
    for (int k = 0; k < 500; k++) begin
      x = 5'($urandom);
      y = 5'($urandom);
      dd = x - y;
      do_op(x, y, {x < y, dd});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
